memory_access: RTL and testbench

- Memory stage of the 5-stage RV32I core. Sits between EX/MEM and the write-back stage.
- Issues data-memory loads and stores over a valid/ready bus and aligns and sign-extends load data.
- Detects misaligned accesses and bus timeouts.
- Drives the registered MEM/WB pipeline register: alu_result, data_result, mem_data_select, rd, reg_write.
- Stalls upstream while a bus access is outstanding.

---
 rtl/memory_access_pkg.sv | 56 +++++
 rtl/memory_access_load_align.sv | 27 ++
 rtl/memory_access.sv | 180 ++++++++++++++++++
 tb/tb_memory_access.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared ISA definitions for the memory stage: funct3 encodings, FSM states,
// the MEM/WB register layout and access-size decode.
package memory_access_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } mem_size_t;

    typedef struct packed {
        logic        valid;
        logic        mem_data_select;
        logic [31:0] alu_result;
        logic [31:0] data_result;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;

    // Encodings that are not defined for the access direction fall back to a word.
    function automatic mem_size_t decode_size(input logic [2:0] funct3, input logic is_store);
        mem_size_t size;
        size = SZ_W;
        if (is_store) begin
            case (funct3)
                F3_SB:   size = SZ_B;
                F3_SH:   size = SZ_H;
                F3_SW:   size = SZ_W;
                default: size = SZ_W;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: size = SZ_B;
                F3_LH, F3_LHU: size = SZ_H;
                F3_LW:         size = SZ_W;
                default:       size = SZ_W;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Load-data lane extraction and sign/zero extension for the memory stage.
module memory_access_load_align
    import memory_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

    // funct3[2] marks the unsigned variants for byte and half loads.
    always_comb begin
        o_data = i_rdata;
        case (decode_size(i_funct3, 1'b0))
            SZ_B:    o_data = i_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    o_data = i_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// RV32I memory stage: issues data-bus accesses, aligns load data, flags
// misaligned and timed-out accesses, and drives the MEM/WB register.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_mem_data_select,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_data_result,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic            misaligned,
    output logic            bus_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_t  r_state;
    mem_state_t  w_state_next;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    mem_wb_t     r_wb;
    mem_wb_t     w_wb_next;
    logic        r_misaligned;
    logic        r_bus_error;

    logic        w_mem_op;
    logic        w_is_store;
    logic        w_is_load;
    logic [1:0]  w_off;
    mem_size_t   w_size;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_req;
    logic        w_stall;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_load_data;

    assign w_mem_op   = ex_valid && (ex_mem_read || ex_mem_write);
    assign w_is_store = ex_mem_write;
    assign w_is_load  = ex_mem_read && !ex_mem_write;
    assign w_off      = ex_alu_result[1:0];
    assign w_size     = decode_size(ex_funct3, w_is_store);

    assign w_misaligned = w_mem_op &&
                          (((w_size == SZ_H) && w_off[0]) || ((w_size == SZ_W) && (w_off != 2'b00)));

    always_comb begin
        w_wdata = ex_store_data;
        w_wstrb = 4'b1111;
        case (w_size)
            SZ_B: begin
                w_wdata = {4{ex_store_data[7:0]}};
                w_wstrb = 4'b0001 << w_off;
            end
            SZ_H: begin
                w_wdata = {2{ex_store_data[15:0]}};
                w_wstrb = 4'b0011 << w_off;
            end
            default: begin
                w_wdata = ex_store_data;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    // Bus fields come straight from EX/MEM, which upstream holds while stalled.
    assign dmem_req   = w_req;
    assign dmem_we    = w_is_store;
    assign dmem_addr  = {ex_alu_result[XLEN-1:2], 2'b00};
    assign dmem_wdata = w_wdata;
    assign dmem_wstrb = w_is_store ? w_wstrb : 4'b0000;
    assign stall      = w_stall;

    memory_access_load_align u_load_align (
        .i_rdata  (dmem_rdata),
        .i_off    (w_off),
        .i_funct3 (ex_funct3),
        .o_data   (w_load_data)
    );

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_req        = 1'b0;
        w_stall      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                w_req = w_mem_op && !w_misaligned;
                if (w_req && !dmem_ready) begin
                    w_stall      = 1'b1;
                    w_state_next = WAIT;
                    w_count_next = CW'(1);
                end
            end
            WAIT: begin
                w_req = 1'b1;
                if (dmem_ready) begin
                    w_state_next = IDLE;
                    w_count_next = '0;
                end else if (r_count == CW'(TIMEOUT_CYCLES)) begin
                    // Abandon: release upstream and let the access fall out as a bubble.
                    w_timeout    = 1'b1;
                    w_state_next = IDLE;
                    w_count_next = '0;
                end else begin
                    w_stall      = 1'b1;
                    w_count_next = r_count + CW'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_count_next = '0;
            end
        endcase
    end

    always_comb begin
        w_wb_next = '0;
        if (!w_stall && ex_valid && !w_misaligned && !w_timeout) begin
            w_wb_next.valid      = 1'b1;
            w_wb_next.reg_write  = ex_reg_write;
            w_wb_next.rd         = ex_rd;
            w_wb_next.alu_result = ex_alu_result;
            if (w_is_load) begin
                w_wb_next.mem_data_select = 1'b1;
                w_wb_next.data_result     = w_load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_wb         <= '0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_wb         <= w_wb_next;
            r_misaligned <= w_misaligned;
            r_bus_error  <= w_timeout;
        end
    end

    assign wb_valid           = r_wb.valid;
    assign wb_mem_data_select = r_wb.mem_data_select;
    assign wb_alu_result      = r_wb.alu_result;
    assign wb_data_result     = r_wb.data_result;
    assign wb_rd              = r_wb.rd;
    assign wb_reg_write       = r_wb.reg_write;
    assign misaligned         = r_misaligned;
    assign bus_error          = r_bus_error;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed vector table, reset
// sequences, and random transactions against a transaction-level model.
module tb_memory_access;

    localparam int TOUT = 4;

    logic        clk;
    logic        reset_n;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_mem_data_select;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_data_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misaligned;
    logic        bus_error;

    memory_access #(.TIMEOUT_CYCLES(TOUT), .XLEN(32)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .ex_valid           (ex_valid),
        .ex_mem_read        (ex_mem_read),
        .ex_mem_write       (ex_mem_write),
        .ex_funct3          (ex_funct3),
        .ex_alu_result      (ex_alu_result),
        .ex_store_data      (ex_store_data),
        .ex_rd              (ex_rd),
        .ex_reg_write       (ex_reg_write),
        .stall              (stall),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_wstrb         (dmem_wstrb),
        .dmem_ready         (dmem_ready),
        .dmem_rdata         (dmem_rdata),
        .wb_valid           (wb_valid),
        .wb_mem_data_select (wb_mem_data_select),
        .wb_alu_result      (wb_alu_result),
        .wb_data_result     (wb_data_result),
        .wb_rd              (wb_rd),
        .wb_reg_write       (wb_reg_write),
        .misaligned         (misaligned),
        .bus_error          (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit          valid;
        bit          rd_en;
        bit          wr_en;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          delay;
        logic [4:0]  rd;
        bit          rw;
    } txn_t;

    typedef struct packed {
        bit          mis;
        bit          tout;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] data;
        bit          sel;
    } exp_t;

    typedef struct {
        string nm;
        txn_t  t;
        exp_t  e;
    } vec_t;

    int n_pass = 0;
    int n_checks = 0;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    endtask

    function automatic txn_t mk(input bit v, input bit r, input bit w, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] rdata, input int delay,
                                input logic [4:0] rd, input bit rw);
        txn_t t;
        t.valid = v; t.rd_en = r; t.wr_en = w; t.f3 = f3; t.addr = addr;
        t.sdata = sdata; t.rdata = rdata; t.delay = delay; t.rd = rd; t.rw = rw;
        return t;
    endfunction

    function automatic exp_t mke(input bit mis, input bit tout, input logic [3:0] wstrb,
                                 input logic [31:0] wdata, input logic [31:0] data, input bit sel);
        exp_t e;
        e.mis = mis; e.tout = tout; e.wstrb = wstrb; e.wdata = wdata; e.data = data; e.sel = sel;
        return e;
    endfunction

    // Transaction-level reference: access size in bytes, shift-based lane select.
    function automatic exp_t model(input txn_t t);
        exp_t        e;
        int          sz;
        int          mask;
        logic [1:0]  off;
        logic [31:0] sh;
        e = '0;
        off = t.addr[1:0];
        if (!(t.valid && (t.rd_en || t.wr_en))) return e;
        if (t.wr_en) sz = (t.f3 == 3'd0) ? 1 : (t.f3 == 3'd1) ? 2 : 4;
        else         sz = (t.f3 == 3'd0 || t.f3 == 3'd4) ? 1 : (t.f3 == 3'd1 || t.f3 == 3'd5) ? 2 : 4;
        e.mis = (sz == 2 && off[0]) || (sz == 4 && off != 2'd0);
        if (e.mis) return e;
        e.tout = t.delay > TOUT;
        if (t.wr_en) begin
            if (sz == 1)      e.wdata = {4{t.sdata[7:0]}};
            else if (sz == 2) e.wdata = {2{t.sdata[15:0]}};
            else              e.wdata = t.sdata;
            mask = ((1 << sz) - 1) << off;
            e.wstrb = mask[3:0];
        end else begin
            e.sel = 1'b1;
            sh = t.rdata >> (8 * off);
            if (sz == 1) begin
                e.data = {24'h0, sh[7:0]};
                if (!t.f3[2] && sh[7]) e.data |= 32'hFFFF_FF00;
            end else if (sz == 2) begin
                e.data = {16'h0, sh[15:0]};
                if (!t.f3[2] && sh[15]) e.data |= 32'hFFFF_0000;
            end else begin
                e.data = t.rdata;
            end
        end
        return e;
    endfunction

    // Called right after a falling edge; returns right after a falling edge.
    task automatic run(input string nm, input txn_t t, input exp_t e);
        bit issue;
        bit ok;
        int k_end;
        issue = t.valid && (t.rd_en || t.wr_en) && !e.mis;
        k_end = !issue ? 0 : ((t.delay > TOUT) ? TOUT : t.delay);
        ex_valid      = t.valid;
        ex_mem_read   = t.rd_en;
        ex_mem_write  = t.wr_en;
        ex_funct3     = t.f3;
        ex_alu_result = t.addr;
        ex_store_data = t.sdata;
        ex_rd         = t.rd;
        ex_reg_write  = t.rw;
        dmem_rdata    = t.rdata;
        dmem_ready    = issue && (t.delay == 0);
        for (int k = 0; k <= k_end; k++) begin
            #1;
            chk({nm, " stall"}, 32'(stall), 32'(k < k_end));
            chk({nm, " dmem_req"}, 32'(dmem_req), 32'(issue));
            if (issue) begin
                chk({nm, " dmem_we"}, 32'(dmem_we), 32'(t.wr_en));
                chk({nm, " dmem_addr"}, dmem_addr, {t.addr[31:2], 2'b00});
                chk({nm, " dmem_wstrb"}, 32'(dmem_wstrb), 32'(t.wr_en ? e.wstrb : 4'b0000));
                if (t.wr_en) chk({nm, " dmem_wdata"}, dmem_wdata, e.wdata);
            end
            @(posedge clk);
            #1;
            if (k < k_end) begin
                chk({nm, " bubble wb_valid"}, 32'(wb_valid), 32'(0));
                @(negedge clk);
                dmem_ready = (k + 1 == t.delay);
            end
        end
        ok = t.valid && !e.mis && !e.tout;
        chk({nm, " wb_valid"}, 32'(wb_valid), 32'(ok));
        chk({nm, " wb_reg_write"}, 32'(wb_reg_write), 32'(ok && t.rw));
        chk({nm, " misaligned"}, 32'(misaligned), 32'(e.mis));
        chk({nm, " bus_error"}, 32'(bus_error), 32'(e.tout));
        if (ok) begin
            chk({nm, " wb_alu_result"}, wb_alu_result, t.addr);
            chk({nm, " wb_rd"}, 32'(wb_rd), 32'(t.rd));
            chk({nm, " wb_mem_data_select"}, 32'(wb_mem_data_select), 32'(e.sel));
            chk({nm, " wb_data_result"}, wb_data_result, e.data);
        end
        @(negedge clk);
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
        dmem_ready   = 1'b0;
        #1;
        chk({nm, " idle dmem_req"}, 32'(dmem_req), 32'(0));
        chk({nm, " idle stall"}, 32'(stall), 32'(0));
        @(posedge clk);
        #1;
        chk({nm, " pulse misaligned"}, 32'(misaligned), 32'(0));
        chk({nm, " pulse bus_error"}, 32'(bus_error), 32'(0));
        chk({nm, " idle wb_valid"}, 32'(wb_valid), 32'(0));
        @(negedge clk);
    endtask

    task automatic chk_wb_zero(input string nm);
        chk({nm, " wb_valid"}, 32'(wb_valid), 32'(0));
        chk({nm, " wb_reg_write"}, 32'(wb_reg_write), 32'(0));
        chk({nm, " wb_mem_data_select"}, 32'(wb_mem_data_select), 32'(0));
        chk({nm, " wb_alu_result"}, wb_alu_result, 32'(0));
        chk({nm, " wb_data_result"}, wb_data_result, 32'(0));
        chk({nm, " wb_rd"}, 32'(wb_rd), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        exp_t e;
        vec_t v;

        vecs.push_back('{"lb_1003",   mk(1,1,0,3'b000,32'h1003,0,32'h80FF_FF7F,0,5'd1,1),  mke(0,0,4'h0,0,32'hFFFF_FF80,1)});
        vecs.push_back('{"lhu_2002",  mk(1,1,0,3'b101,32'h2002,0,32'h8001_1234,3,5'd2,1),  mke(0,0,4'h0,0,32'h0000_8001,1)});
        vecs.push_back('{"sh_3002",   mk(1,0,1,3'b001,32'h3002,32'h0000_ABCD,0,1,5'd3,0), mke(0,0,4'b1100,32'hABCD_ABCD,0,0)});
        vecs.push_back('{"lw_4001",   mk(1,1,0,3'b010,32'h4001,0,32'h1234_5678,0,5'd4,1),  mke(1,0,4'h0,0,0,0)});
        vecs.push_back('{"lw_tout",   mk(1,1,0,3'b010,32'h5000,0,32'h5555_AAAA,9,5'd5,1),  mke(0,1,4'h0,0,0,1)});
        vecs.push_back('{"add",       mk(1,0,0,3'b000,32'h1234_5678,0,0,0,5'd6,1),         mke(0,0,4'h0,0,0,0)});
        vecs.push_back('{"sb_6001",   mk(1,0,1,3'b000,32'h6001,32'h0000_00A5,0,0,5'd7,0),  mke(0,0,4'b0010,32'hA5A5_A5A5,0,0)});
        vecs.push_back('{"lh_7000",   mk(1,1,0,3'b001,32'h7000,0,32'h0000_8765,2,5'd8,1),  mke(0,0,4'h0,0,32'hFFFF_8765,1)});
        vecs.push_back('{"lbu_8002",  mk(1,1,0,3'b100,32'h8002,0,32'h00FE_0000,0,5'd9,1),  mke(0,0,4'h0,0,32'h0000_00FE,1)});
        vecs.push_back('{"l011_9000", mk(1,1,0,3'b011,32'h9000,0,32'hDEAD_BEEF,1,5'd10,1), mke(0,0,4'h0,0,32'hDEAD_BEEF,1)});
        vecs.push_back('{"sw_edge",   mk(1,0,1,3'b010,32'hA000,32'h1122_3344,0,TOUT,5'd11,0), mke(0,0,4'b1111,32'h1122_3344,0,0)});
        vecs.push_back('{"sh_b001",   mk(1,0,1,3'b001,32'hB001,32'h0000_FFFF,0,0,5'd12,0), mke(1,0,4'h0,0,0,0)});
        vecs.push_back('{"lw_c000",   mk(1,1,0,3'b010,32'hC000,0,32'hCAFE_F00D,2,5'd13,1), mke(0,0,4'h0,0,32'hCAFE_F00D,1)});
        vecs.push_back('{"lb_pos",    mk(1,1,0,3'b000,32'hE001,0,32'h0000_7F00,0,5'd14,1), mke(0,0,4'h0,0,32'h0000_007F,1)});

        // Reset held with a valid instruction in EX/MEM must keep MEM/WB cleared.
        reset_n       = 1'b0;
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_funct3     = 3'b000;
        ex_alu_result = 32'hFFFF_FFFF;
        ex_store_data = 32'h0;
        ex_rd         = 5'd31;
        ex_reg_write  = 1'b1;
        dmem_ready    = 1'b0;
        dmem_rdata    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_wb_zero("reset");
        chk("reset misaligned", 32'(misaligned), 32'(0));
        chk("reset bus_error", 32'(bus_error), 32'(0));
        @(negedge clk);
        reset_n  = 1'b1;
        ex_valid = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            v = vecs[i];
            run(v.nm, v.t, v.e);
        end

        // Reset while an access is waiting on the bus.
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b1;
        ex_mem_write  = 1'b0;
        ex_funct3     = 3'b010;
        ex_alu_result = 32'hD000;
        ex_rd         = 5'd15;
        ex_reg_write  = 1'b1;
        dmem_ready    = 1'b0;
        #1;
        chk("rst_wait stall", 32'(stall), 32'(1));
        @(negedge clk);
        #1;
        chk("rst_wait in WAIT dmem_req", 32'(dmem_req), 32'(1));
        reset_n     = 1'b0;
        ex_valid    = 1'b0;
        ex_mem_read = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_wait dmem_req", 32'(dmem_req), 32'(0));
        chk("rst_wait stall", 32'(stall), 32'(0));
        chk_wb_zero("rst_wait");
        @(negedge clk);
        reset_n = 1'b1;
        t = mk(1,0,0,3'b000,32'h0BAD_F00D,0,0,0,5'd16,1);
        run("add_after_rst", t, model(t));

        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            t.valid = ($urandom_range(0, 9) != 0);
            t.rd_en = (kind <= 1);
            t.wr_en = (kind == 2);
            t.f3    = 3'($urandom_range(0, 7));
            if (kind == 2 && $urandom_range(0, 3) != 0) t.f3 = 3'($urandom_range(0, 2));
            t.addr  = $urandom;
            if ($urandom_range(0, 1) == 1) t.addr[1:0] = 2'b00;
            t.sdata = $urandom;
            t.rdata = $urandom;
            t.delay = int'($urandom_range(0, TOUT + 2));
            t.rd    = 5'($urandom_range(0, 31));
            t.rw    = ($urandom_range(0, 3) != 0);
            e = model(t);
            run($sformatf("rnd%0d", i), t, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
